// File: rtl/ebus_arbiter.sv
// ebus_arbiter: registered EBUS arbiter and data mux with fixed/round-robin arbitration,
// ownership hold, hold timeout and contention tracking. EBUS_CONFLICT_LOG_EN adds conflict_mask.
module ebus_arbiter #(
    parameter int N_DRV    = 13,
    parameter int DATA_W   = 36,
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 16,
    parameter int IDX_W    = $clog2(N_DRV)
) (
    input  logic                    clk,
    input  logic                    CROBAR_N,
    input  logic [N_DRV-1:0]        drv_req,
    input  logic [N_DRV*DATA_W-1:0] drv_data,
    input  logic                    rr_mode,
    input  logic                    conflict_clr,
    output logic [N_DRV-1:0]        drv_gnt,
    output logic [IDX_W-1:0]        gnt_id,
    output logic [DATA_W-1:0]       ebus_data,
    output logic                    ebus_valid,
    output logic                    timeout,
    output logic                    conflict,
    output logic [CNT_W-1:0]        conflict_cnt
`ifdef EBUS_CONFLICT_LOG_EN
    ,
    output logic [N_DRV-1:0]        conflict_mask
`endif
);

    localparam int HOLD_W = $clog2(MAX_HOLD);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t             state, state_nx;
    logic [HOLD_W-1:0]  hold_cnt, hold_nx;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_nx;
    logic [IDX_W-1:0]   win, id_nx;
    logic [N_DRV-1:0]   arb_set, gnt_nx;
    logic [DATA_W-1:0]  data_nx;
    logic               valid_nx, conflict_nx;
    logic [CNT_W-1:0]   cnt_nx;
    logic               do_arb, found, contention, owner_req;
    logic [DATA_W-1:0]  data_arr [N_DRV];

    for (genvar g = 0; g < N_DRV; g++) begin : g_unpack
        assign data_arr[g] = drv_data[g*DATA_W +: DATA_W];
    end

    // Decide whether this cycle arbitrates and which requests are considered.
    always_comb begin
        do_arb    = 1'b0;
        arb_set   = '0;
        timeout   = 1'b0;
        owner_req = drv_req[gnt_id];
        case (state)
            IDLE: begin
                if (|drv_req) begin
                    do_arb  = 1'b1;
                    arb_set = drv_req;
                end
            end
            OWNED: begin
                if (!owner_req) begin
                    do_arb  = 1'b1;
                    arb_set = drv_req;
                end else if (hold_cnt == HOLD_W'(MAX_HOLD - 1)) begin
                    do_arb  = 1'b1;
                    timeout = 1'b1;
                    arb_set = drv_req & ~drv_gnt;   // owner masked on forced release
                end
            end
            default: ;
        endcase
    end

    // Winner search: from index 0 in fixed mode, from rr_ptr (wrapping) in round-robin mode.
    always_comb begin : pick
        int unsigned idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int unsigned k = 0; k < N_DRV; k++) begin
            idx = k;
            if (rr_mode) begin
                idx = k + rr_ptr;
                if (idx >= N_DRV) idx = idx - N_DRV;
            end
            if (!found && arb_set[IDX_W'(idx)]) begin
                found = 1'b1;
                win   = IDX_W'(idx);
            end
        end
    end

    assign contention = do_arb && ((arb_set & (arb_set - N_DRV'(1))) != '0);

    always_comb begin
        state_nx  = state;
        gnt_nx    = drv_gnt;
        id_nx     = gnt_id;
        valid_nx  = ebus_valid;
        data_nx   = ebus_data;
        hold_nx   = hold_cnt;
        rr_ptr_nx = rr_ptr;
        if (do_arb) begin
            if (found) begin
                state_nx  = OWNED;
                gnt_nx    = N_DRV'(1) << win;
                id_nx     = win;
                valid_nx  = 1'b1;
                data_nx   = data_arr[win];
                hold_nx   = '0;
                rr_ptr_nx = (win == IDX_W'(N_DRV - 1)) ? '0 : win + IDX_W'(1);
            end else begin
                state_nx  = IDLE;
                gnt_nx    = '0;
                id_nx     = '0;
                valid_nx  = 1'b0;
                data_nx   = '0;
                hold_nx   = '0;
            end
        end else if (state == OWNED) begin
            hold_nx = hold_cnt + HOLD_W'(1);
            data_nx = data_arr[gnt_id];
        end else begin
            state_nx = IDLE;
            gnt_nx   = '0;
            id_nx    = '0;
            valid_nx = 1'b0;
            data_nx  = '0;
            hold_nx  = '0;
        end
    end

    // A contention event outranks a simultaneous clear, restarting the count at 1.
    always_comb begin
        conflict_nx = conflict;
        cnt_nx      = conflict_cnt;
        if (contention) begin
            conflict_nx = 1'b1;
            if (conflict_clr)
                cnt_nx = CNT_W'(1);
            else if (conflict_cnt != '1)
                cnt_nx = conflict_cnt + CNT_W'(1);
        end else if (conflict_clr) begin
            conflict_nx = 1'b0;
            cnt_nx      = '0;
        end
    end

    always_ff @(posedge clk or negedge CROBAR_N) begin
        if (!CROBAR_N) begin
            state        <= IDLE;
            hold_cnt     <= '0;
            rr_ptr       <= '0;
            drv_gnt      <= '0;
            gnt_id       <= '0;
            ebus_data    <= '0;
            ebus_valid   <= 1'b0;
            conflict     <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            state        <= state_nx;
            hold_cnt     <= hold_nx;
            rr_ptr       <= rr_ptr_nx;
            drv_gnt      <= gnt_nx;
            gnt_id       <= id_nx;
            ebus_data    <= data_nx;
            ebus_valid   <= valid_nx;
            conflict     <= conflict_nx;
            conflict_cnt <= cnt_nx;
        end
    end

`ifdef EBUS_CONFLICT_LOG_EN
    // conflict is low exactly when no event has occurred since reset or the last clear.
    always_ff @(posedge clk or negedge CROBAR_N) begin
        if (!CROBAR_N)
            conflict_mask <= '0;
        else if (contention && (conflict_clr || !conflict))
            conflict_mask <= drv_req;
        else if (conflict_clr && !contention)
            conflict_mask <= '0;
    end
`endif

endmodule

// File: tb/tb_ebus_arbiter.sv
// Self-checking bench for ebus_arbiter: per-scenario tasks with a queue of expected outputs.
module tb_ebus_arbiter;

    localparam int N  = 13;
    localparam int DW = 36;
    localparam int MH = 16;
    localparam int CW = 4;
    localparam int IW = $clog2(N);

    logic            clk = 1'b0;
    logic            CROBAR_N = 1'b0;
    logic [N-1:0]    drv_req = '0;
    logic [N*DW-1:0] drv_data = '0;
    logic            rr_mode = 1'b0;
    logic            conflict_clr = 1'b0;
    logic [N-1:0]    drv_gnt;
    logic [IW-1:0]   gnt_id;
    logic [DW-1:0]   ebus_data;
    logic            ebus_valid, timeout, conflict;
    logic [CW-1:0]   conflict_cnt;
`ifdef EBUS_CONFLICT_LOG_EN
    logic [N-1:0]    conflict_mask;
`endif

    always #5 clk = ~clk;

    ebus_arbiter #(.N_DRV(N), .DATA_W(DW), .MAX_HOLD(MH), .CNT_W(CW)) dut (
        .clk          (clk),
        .CROBAR_N     (CROBAR_N),
        .drv_req      (drv_req),
        .drv_data     (drv_data),
        .rr_mode      (rr_mode),
        .conflict_clr (conflict_clr),
        .drv_gnt      (drv_gnt),
        .gnt_id       (gnt_id),
        .ebus_data    (ebus_data),
        .ebus_valid   (ebus_valid),
        .timeout      (timeout),
        .conflict     (conflict),
        .conflict_cnt (conflict_cnt)
`ifdef EBUS_CONFLICT_LOG_EN
        ,
        .conflict_mask(conflict_mask)
`endif
    );

    typedef struct packed {
        logic [N-1:0]  gnt;
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic          valid;
        logic          conf;
        logic [CW-1:0] cnt;
    } obs_t;

    obs_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic obs_t observe();
        obs_t o;
        o.gnt = drv_gnt; o.id = gnt_id; o.data = ebus_data;
        o.valid = ebus_valid; o.conf = conflict; o.cnt = conflict_cnt;
        return o;
    endfunction

    function automatic obs_t mk(int own, logic [DW-1:0] d, logic cf, int cnt);
        obs_t e;
        e.gnt   = (own < 0) ? '0 : (N'(1) << own);
        e.id    = (own < 0) ? '0 : IW'(own);
        e.data  = (own < 0) ? '0 : d;
        e.valid = (own >= 0);
        e.conf  = cf;
        e.cnt   = CW'(cnt);
        return e;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("gnt=%h id=%0d data=%h valid=%b conflict=%b cnt=%0d",
                         o.gnt, o.id, o.data, o.valid, o.conf, o.cnt);
    endfunction

    function automatic logic [DW-1:0] dval(int i);
        if (i == 2) return 36'o123;
        return DW'(i) * 36'h0_1111_1111 + 36'h5;
    endfunction

    task automatic set_data(int i, logic [DW-1:0] v);
        drv_data[i*DW +: DW] = v;
    endtask

    task automatic test_reset();
        obs_t o;
        CROBAR_N = 1'b0;
        drv_req  = 13'h004;
        repeat (2) @(posedge clk);
        #1;
        o = observe();
        n_cmp++;
        if (o !== '0 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: got %s timeout=%b, want all zero", fmt(o), timeout);
        end
        drv_req = '0;
        #2 CROBAR_N = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fixed();
        logic [N-1:0] rq [8] = '{13'h004, 13'h000, 13'h00C, 13'h00C, 13'h008, 13'h000, 13'h0A0, 13'h000};
        obs_t ex [8];
        obs_t e, o;
        ex[0] = mk(2, dval(2), 0, 0);
        ex[1] = mk(-1, '0, 0, 0);
        ex[2] = mk(2, dval(2), 1, 1);
        ex[3] = mk(2, dval(2), 1, 1);
        ex[4] = mk(3, dval(3), 1, 1);
        ex[5] = mk(-1, '0, 1, 1);
        ex[6] = mk(5, dval(5), 1, 2);
        ex[7] = mk(-1, '0, 1, 2);
        rr_mode = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drv_req = rq[i];
            sb.push_back(ex[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            o = observe();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL fixed[%0d]: got %s want %s", i, fmt(o), fmt(e));
            end
        end
`ifdef EBUS_CONFLICT_LOG_EN
        n_cmp++;
        if (conflict_mask !== 13'h00C) begin
            n_fail++;
            $display("FAIL fixed_mask: got %h want %h", conflict_mask, 13'h00C);
        end
`endif
    endtask

    task automatic test_rr();
        logic [N-1:0] rq [7] = '{13'h007, 13'h006, 13'h005, 13'h003, 13'h006, 13'h005, 13'h000};
        int own [7] = '{0, 1, 2, 0, 1, 2, -1};
        int cnt [7] = '{1, 2, 3, 4, 5, 6, 6};
        obs_t e, o;
        CROBAR_N = 1'b0;
        #2 CROBAR_N = 1'b1;
        rr_mode = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drv_req = rq[i];
            sb.push_back(mk(own[i], (own[i] < 0) ? '0 : dval(own[i]), 1, cnt[i]));
            @(posedge clk); #1;
            e = sb.pop_front();
            o = observe();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL rr[%0d]: got %s want %s", i, fmt(o), fmt(e));
            end
        end
        rr_mode = 1'b0;
    endtask

    task automatic test_timeout();
        logic [DW-1:0] v;
        obs_t e, o;
        // driver 5 alone: forced off after 16 owned cycles, one idle cycle, then regranted
        for (int k = 0; k < 19; k++) begin
            v = 36'h9_0000_0000 + DW'(k);
            drv_req = (k == 18) ? 13'h000 : 13'h020;
            set_data(5, v);
            #1;
            n_cmp++;
            if (timeout !== (k == 16)) begin
                n_fail++;
                $display("FAIL timeout_pulse[%0d]: got %b want %b", k, timeout, (k == 16));
            end
            if (k == 16 || k == 18) sb.push_back(mk(-1, '0, 1, 6));
            else                    sb.push_back(mk(5, v, 1, 6));
            @(posedge clk); #1;
            e = sb.pop_front();
            o = observe();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL timeout_solo[%0d]: got %s want %s", k, fmt(o), fmt(e));
            end
        end
        // drivers 5 and 7: forced release hands the bus to 7 despite 5 being lower
        for (int k = 0; k < 18; k++) begin
            v = 36'hA_0000_0000 + DW'(k);
            drv_req = (k == 17) ? 13'h000 : 13'h0A0;
            set_data(5, v);
            #1;
            n_cmp++;
            if (timeout !== (k == 16)) begin
                n_fail++;
                $display("FAIL timeout_pulse2[%0d]: got %b want %b", k, timeout, (k == 16));
            end
            if (k < 16)       sb.push_back(mk(5, v, 1, 7));
            else if (k == 16) sb.push_back(mk(7, dval(7), 1, 7));
            else              sb.push_back(mk(-1, '0, 1, 7));
            @(posedge clk); #1;
            e = sb.pop_front();
            o = observe();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL timeout_handoff[%0d]: got %s want %s", k, fmt(o), fmt(e));
            end
        end
        set_data(5, dval(5));
    endtask

    task automatic test_saturate();
        int own = -1;
        int nxt;
        int cnt = 7;
        obs_t e, o;
        logic [N-1:0] mexp;
        for (int i = 0; i < 12; i++) begin
            drv_req = (own < 0) ? 13'h003 : (13'h007 & ~(N'(1) << own));
            nxt = (own == 0) ? 1 : 0;
            cnt = (cnt < 15) ? cnt + 1 : 15;
            sb.push_back(mk(nxt, dval(nxt), 1, cnt));
            @(posedge clk); #1;
            e = sb.pop_front();
            o = observe();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL saturate[%0d]: got %s want %s", i, fmt(o), fmt(e));
            end
            own = nxt;
        end
        // clear together with an event: event wins, count restarts at 1
        drv_req = 13'h007 & ~(N'(1) << own);
        mexp = drv_req;
        nxt = (own == 0) ? 1 : 0;
        conflict_clr = 1'b1;
        sb.push_back(mk(nxt, dval(nxt), 1, 1));
        @(posedge clk); #1;
        e = sb.pop_front();
        o = observe();
        n_cmp++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL clr_with_event: got %s want %s", fmt(o), fmt(e));
        end
`ifdef EBUS_CONFLICT_LOG_EN
        n_cmp++;
        if (conflict_mask !== mexp) begin
            n_fail++;
            $display("FAIL clr_event_mask: got %h want %h", conflict_mask, mexp);
        end
`endif
        own = nxt;
        // clear alone while the owner holds
        drv_req = N'(1) << own;
        sb.push_back(mk(own, dval(own), 0, 0));
        @(posedge clk); #1;
        e = sb.pop_front();
        o = observe();
        n_cmp++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL clr_alone: got %s want %s", fmt(o), fmt(e));
        end
`ifdef EBUS_CONFLICT_LOG_EN
        n_cmp++;
        if (conflict_mask !== '0) begin
            n_fail++;
            $display("FAIL clr_alone_mask: got %h want 0", conflict_mask);
        end
`endif
        conflict_clr = 1'b0;
        drv_req = '0;
        sb.push_back(mk(-1, '0, 0, 0));
        @(posedge clk); #1;
        e = sb.pop_front();
        o = observe();
        n_cmp++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL clr_idle: got %s want %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_async_reset();
        obs_t e, o;
        drv_req = 13'h018;
        sb.push_back(mk(3, dval(3), 1, 1));
        @(posedge clk); #1;
        e = sb.pop_front();
        o = observe();
        n_cmp++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL areset_own: got %s want %s", fmt(o), fmt(e));
        end
        #1 CROBAR_N = 1'b0;
        #1;
        o = observe();
        n_cmp++;
        if (o !== '0 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_async: got %s timeout=%b, want all zero", fmt(o), timeout);
        end
        @(posedge clk); #1;
        o = observe();
        n_cmp++;
        if (o !== '0) begin
            n_fail++;
            $display("FAIL areset_held: got %s, want all zero", fmt(o));
        end
        CROBAR_N = 1'b1;
        sb.push_back(mk(3, dval(3), 1, 1));
        @(posedge clk); #1;
        e = sb.pop_front();
        o = observe();
        n_cmp++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL areset_regrant: got %s want %s", fmt(o), fmt(e));
        end
        drv_req = '0;
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) set_data(i, dval(i));
        test_reset();
        test_fixed();
        test_rr();
        test_timeout();
        test_saturate();
        test_async_reset();
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
